fa_bist: RTL and testbench

- Built-in self-test controller for a 1-bit full adder. Pairs with the existing full adder as the driving and checking end of its interface.
- Drives `a`/`b`/`cin` through all 8 input vectors in ascending order, 000 to 111. The vector is `{a,b,cin}`, with `a` as the MSB.
- Samples the adder's `sum`/`cout` after a programmable settle time and compares them against the ideal result. Reports pass/fail, an error count and the first failing vector.
- Sits beside the adder instance in the top level. Replaces a simulation-only stimulus bench with synthesizable on-chip test.

---
 rtl/fa_bist.sv | 171 +++++++++++++++++
 tb/tb_fa_bist.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fa_bist.sv
// rtl/fa_bist.sv - Built-in self-test controller for a 1-bit full adder
//
// Drives {a,b,cin} through vectors 000..111 in ascending order. Each vector
// is held for SETTLE_CYCLES cycles, and then sum/cout are checked against the
// ideal full-adder result. The block reports pass/fail, a saturating error
// count and the first failing vector.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             level; begins a run when sampled in IDLE or DONE
//   a, b, cin         stimulus to the adder under test (registered)
//   sum, cout         adder responses, sampled only in CHECK
//   busy              a run is in progress
//   done              the run has completed; held until the next start or reset
//   pass              valid with done; 1 when err_count == 0
//   err_count         number of mismatching vectors, saturating
//   fail_valid        a first failing vector has been captured
//   fail_vec          {a,b,cin} of the first failing vector

module fa_bist #(
    parameter int SETTLE_CYCLES = 1,    // 1..15
    parameter int ERR_W         = 4     // >= 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             sum,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [2:0]       fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX       = '1;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [3:0]       settle_q, settle_d;
    logic [2:0]       abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [2:0]       fail_vec_q, fail_vec_d;

    logic exp_sum, exp_cout, mismatch;

    always_comb begin
        exp_sum  = abc_q[2] ^ abc_q[1] ^ abc_q[0];
        exp_cout = (abc_q[2] & abc_q[1]) | (abc_q[2] & abc_q[0]) | (abc_q[1] & abc_q[0]);
        mismatch = (sum != exp_sum) || (cout != exp_cout);
    end

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        abc_d        = abc_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start from DONE behaves exactly like one from IDLE:
                // every result of the previous run is discarded.
                if (start) begin
                    state_d      = S_WAIT;
                    vec_d        = 3'd0;
                    abc_d        = 3'd0;
                    settle_d     = SETTLE_RELOAD;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 3'd0;
                end
            end
            S_WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = S_DONE;
                    abc_d   = 3'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // err_d already includes the last vector's outcome.
                    pass_d  = (err_d == '0);
                end else begin
                    state_d  = S_WAIT;
                    vec_d    = vec_q + 3'd1;
                    abc_d    = vec_q + 3'd1;
                    settle_d = SETTLE_RELOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= 3'd0;
            settle_q     <= 4'd0;
            abc_q        <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            abc_q        <= abc_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign a          = abc_q[2];
    assign b          = abc_q[1];
    assign cin        = abc_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_fa_bist.sv
// tb/tb_fa_bist.sv - Self-checking bench for fa_bist with a fault-injectable adder model
module tb_fa_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [2:0]       start_v;
    logic [7:0]       smask [3];
    logic [7:0]       cmask [3];

    logic [2:0]       busy_v, done_v, pass_v, fv_v;
    logic [2:0][2:0]  abc_v, fvec_v;
    logic [2:0][3:0]  err_v;

    // Instance 0: SETTLE=1, ERR_W=4. Instance 1: SETTLE=1, ERR_W=2.
    // Instance 2: SETTLE=3, ERR_W=4.
    genvar g;
    for (g = 0; g < 3; g++) begin : gi
        localparam int S  = (g == 2) ? 3 : 1;
        localparam int EW = (g == 1) ? 2 : 4;
        logic a, b, c, s, co, bz, dn, ps, fv;
        logic [2:0]    fvec;
        logic [EW-1:0] ec;

        fa_bist #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[g]),
            .a(a), .b(b), .cin(c), .sum(s), .cout(co),
            .busy(bz), .done(dn), .pass(ps), .err_count(ec),
            .fail_valid(fv), .fail_vec(fvec)
        );

        // Adder with per-vector flip masks to plant faults.
        assign s  = (a ^ b ^ c) ^ smask[g][{a, b, c}];
        assign co = (({1'b0, a} + {1'b0, b} + {1'b0, c}) >= 2'd2) ^ cmask[g][{a, b, c}];

        assign abc_v[g]  = {a, b, c};
        assign busy_v[g] = bz;
        assign done_v[g] = dn;
        assign pass_v[g] = ps;
        assign fv_v[g]   = fv;
        assign fvec_v[g] = fvec;
        assign err_v[g]  = 4'(ec);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: walk all 8 vectors, compare faulty adder to arithmetic ideal.
    function automatic void model(input logic [7:0] sm, input logic [7:0] cm, input int ew,
                                  output int cnt, output int fv, output int fvec);
        cnt = 0; fv = 0; fvec = 0;
        for (int v = 0; v < 8; v++) begin
            int ones = ((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1);
            int is = ones % 2;
            int ic = ones / 2;
            int gs = is ^ int'(sm[v]);
            int gc = ic ^ int'(cm[v]);
            if (gs != is || gc != ic) begin
                if (cnt < (1 << ew) - 1) cnt++;
                if (fv == 0) begin
                    fv = 1;
                    fvec = v;
                end
            end
        end
    endfunction

    // One run on instance k. Sampling 1 time unit after each rising edge;
    // step n is the n-th edge after the one that sampled start.
    task automatic run(input int k, input bit hold, input int exp_err, input int exp_fv,
                       input int exp_fvec, input string tag);
        int per = ((k == 2) ? 3 : 1) + 1;
        @(negedge clk);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_v[k] = 1'b0;
        for (int n = 0; n < 8 * per; n++) begin
            chk({tag, "_vec"},  int'(abc_v[k]), n / per);
            chk({tag, "_busy"}, int'(busy_v[k]), 1);
            chk({tag, "_done_early"}, int'(done_v[k]), 0);
            if (n == 0) begin
                chk({tag, "_clr_err"},  int'(err_v[k]), 0);
                chk({tag, "_clr_fv"},   int'(fv_v[k]), 0);
                chk({tag, "_clr_pass"}, int'(pass_v[k]), 0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_done"},     int'(done_v[k]), 1);
        chk({tag, "_busy_end"}, int'(busy_v[k]), 0);
        chk({tag, "_abc_end"},  int'(abc_v[k]), 0);
        chk({tag, "_err"},      int'(err_v[k]), exp_err);
        chk({tag, "_fv"},       int'(fv_v[k]), exp_fv);
        chk({tag, "_fvec"},     int'(fvec_v[k]), exp_fvec);
        chk({tag, "_pass"},     int'(pass_v[k]), (exp_err == 0) ? 1 : 0);
        if (hold) begin
            @(posedge clk); #1;
            chk({tag, "_restart_done"}, int'(done_v[k]), 0);
            chk({tag, "_restart_busy"}, int'(busy_v[k]), 1);
            chk({tag, "_restart_err"},  int'(err_v[k]), 0);
            chk({tag, "_restart_fv"},   int'(fv_v[k]), 0);
            start_v[k] = 1'b0;
            for (int t = 0; t < 100 && !done_v[k]; t++) begin
                @(posedge clk); #1;
            end
            chk({tag, "_restart_finish"}, int'(done_v[k]), 1);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] sm;
        logic [7:0] cm;
        bit         hold;
        int         err;
        int         fv;
        int         fvec;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{0, 8'h00, 8'h00, 1'b0, 0, 0, 0};   // ideal adder
        tbl[1] = '{0, 8'h00, 8'hE8, 1'b0, 4, 1, 3};   // cout stuck at 0
        tbl[2] = '{1, 8'hFF, 8'h00, 1'b0, 3, 1, 0};   // sum inverted, 2-bit counter saturates
        tbl[3] = '{0, 8'h00, 8'h00, 1'b0, 0, 0, 0};   // ideal again, started from DONE
        tbl[4] = '{2, 8'h00, 8'h00, 1'b1, 0, 0, 0};   // start held, SETTLE=3

        rst_n   = 1'b0;
        start_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            smask[i] = 8'h00;
            cmask[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_abc",  int'(abc_v[i]), 0);
            chk("rst_busy", int'(busy_v[i]), 0);
            chk("rst_done", int'(done_v[i]), 0);
            chk("rst_pass", int'(pass_v[i]), 0);
            chk("rst_err",  int'(err_v[i]), 0);
            chk("rst_fv",   int'(fv_v[i]), 0);
            chk("rst_fvec", int'(fvec_v[i]), 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            smask[tbl[i].k] = tbl[i].sm;
            cmask[tbl[i].k] = tbl[i].cm;
            run(tbl[i].k, tbl[i].hold, tbl[i].err, tbl[i].fv, tbl[i].fvec, $sformatf("tbl%0d", i));
        end

        // Random fault patterns against the reference model.
        for (int r = 0; r < 6; r++) begin
            int k, e, f, fvv;
            k = int'($urandom_range(0, 1));
            smask[k] = 8'($urandom);
            cmask[k] = 8'($urandom);
            model(smask[k], cmask[k], (k == 1) ? 2 : 4, e, f, fvv);
            run(k, 1'b0, e, f, fvv, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset during vector 5, then a clean run.
        smask[0] = 8'h00;
        cmask[0] = 8'h4C;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int t = 0; t < 40 && abc_v[0] != 3'd5; t++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_reach_vec5", int'(abc_v[0]), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_abc",  int'(abc_v[0]), 0);
        chk("rstmid_busy", int'(busy_v[0]), 0);
        chk("rstmid_done", int'(done_v[0]), 0);
        chk("rstmid_err",  int'(err_v[0]), 0);
        chk("rstmid_fv",   int'(fv_v[0]), 0);
        chk("rstmid_fvec", int'(fvec_v[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cmask[0] = 8'h00;
        run(0, 1'b0, 0, 0, 0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
